// File: rtl/avalon_bridge_pkg.sv
// Shared types for the Avalon-MM pipeline bridge: response codes and the
// command word carried through the skid buffer.
package avalon_bridge_pkg;

    localparam int unsigned AVALON_ADDR_W = 32;
    localparam int unsigned AVALON_DATA_W = 32;

    typedef enum logic [1:0] {
        OKAY        = 2'b00,
        RESERVED    = 2'b01,
        SLVERR      = 2'b10,
        DECODEERROR = 2'b11
    } avalon_resp_e;

    typedef struct packed {
        logic [AVALON_ADDR_W-1:0]   addr;
        logic [AVALON_DATA_W/8-1:0] be;
        logic [AVALON_DATA_W-1:0]   wdata;
        logic                       read;
        logic                       write;
    } avalon_cmd_t;

endpackage

// File: rtl/avalon_cmd_skid_buffer.sv
// Two-entry registered skid buffer: the main entry feeds the consumer and the
// skid entry catches the one command that arrives while the main entry stalls.
module avalon_cmd_skid_buffer
    import avalon_bridge_pkg::*;
#(
    parameter type cmd_t = avalon_cmd_t
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  cmd_t in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output cmd_t out_data_o
);

    cmd_t main_q, main_d, skid_q, skid_d;
    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic main_free;
    logic in_fire;

    // Ready depends only on registered state, so upstream never sees the
    // downstream stall combinationally.
    assign in_ready_o  = ~skid_valid_q;
    assign in_fire     = in_valid_i & ~skid_valid_q;
    assign main_free   = ~main_valid_q | out_ready_i;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_q;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (main_free) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d       = in_data_i;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = in_data_i;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: rtl/avalon_main_pipeline_bridge.sv
// Registered Avalon-MM bridge for the core's data master: skid-buffered command
// path, outstanding-read cap and a registered response stage.
module avalon_main_pipeline_bridge
    import avalon_bridge_pkg::*;
#(
    parameter int unsigned AddrWidth       = 32,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned MaxPendingReads = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [AddrWidth-1:0]                 s_address,
    input  logic [DataWidth/8-1:0]               s_byteenable,
    input  logic                                 s_read,
    input  logic                                 s_write,
    input  logic [DataWidth-1:0]                 s_writedata,
    output logic                                 s_waitrequest,
    output logic [DataWidth-1:0]                 s_readdata,
    output logic                                 s_readdatavalid,
    output logic [1:0]                           s_response,
    output logic [AddrWidth-1:0]                 m_address,
    output logic [DataWidth/8-1:0]               m_byteenable,
    output logic                                 m_read,
    output logic                                 m_write,
    output logic [DataWidth-1:0]                 m_writedata,
    input  logic                                 m_waitrequest,
    input  logic [DataWidth-1:0]                 m_readdata,
    input  logic                                 m_readdatavalid,
    input  logic [1:0]                           m_response,
    output logic [$clog2(MaxPendingReads+1)-1:0] pending_o,
    output logic                                 protocol_err_o
);

    localparam int unsigned PendW = $clog2(MaxPendingReads + 1);
    localparam logic [PendW-1:0] PendMax = PendW'(MaxPendingReads);

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
        logic                   read;
        logic                   write;
    } bridge_cmd_t;

    bridge_cmd_t in_cmd, main_cmd;
    logic init_q;
    logic skid_ready, main_valid, main_ready;
    logic accept, illegal_cmd;
    logic read_limit, read_issue, rsp_fwd, rsp_stray;
    logic [PendW-1:0] pending_q, pending_d;
    logic err_q, err_d;
    logic rvalid_q;
    logic [DataWidth-1:0] rdata_q;
    logic [1:0] resp_q;

    assign s_waitrequest = ~skid_ready | init_q;
    assign accept        = (s_read | s_write) & ~s_waitrequest;
    assign illegal_cmd   = accept & s_read & s_write;

    // A simultaneous read+write is issued as the write alone.
    always_comb begin
        in_cmd       = '0;
        in_cmd.addr  = s_address;
        in_cmd.be    = s_byteenable;
        in_cmd.wdata = s_writedata;
        in_cmd.read  = s_read & ~s_write;
        in_cmd.write = s_write;
    end

    avalon_cmd_skid_buffer #(
        .cmd_t(bridge_cmd_t)
    ) u_cmd_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_valid_i (accept),
        .in_ready_o (skid_ready),
        .in_data_i  (in_cmd),
        .out_valid_o(main_valid),
        .out_ready_i(main_ready),
        .out_data_o (main_cmd)
    );

    // A read held at the limit also blocks every later command behind it.
    assign read_limit   = (pending_q == PendMax);
    assign main_ready   = ~m_waitrequest & ~(main_cmd.read & read_limit);
    assign m_read       = main_valid & main_cmd.read & ~read_limit;
    assign m_write      = main_valid & main_cmd.write;
    assign m_address    = main_cmd.addr;
    assign m_byteenable = main_cmd.be;
    assign m_writedata  = main_cmd.wdata;

    assign read_issue = m_read & ~m_waitrequest;
    assign rsp_fwd    = m_readdatavalid & (pending_q != '0);
    assign rsp_stray  = m_readdatavalid & (pending_q == '0);

    always_comb begin
        pending_d = pending_q;
        if (read_issue && !rsp_fwd && pending_q != PendMax) begin
            pending_d = pending_q + 1'b1;
        end else if (!read_issue && rsp_fwd) begin
            pending_d = pending_q - 1'b1;
        end
        err_d = err_q | rsp_stray | illegal_cmd;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_q    <= 1'b1;
            pending_q <= '0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= OKAY;
        end else begin
            init_q    <= 1'b0;
            pending_q <= pending_d;
            err_q     <= err_d;
            rvalid_q  <= rsp_fwd;
            if (rsp_fwd) begin
                rdata_q <= m_readdata;
                resp_q  <= m_response;
            end
        end
    end

    assign s_readdatavalid = rvalid_q;
    assign s_readdata      = rdata_q;
    assign s_response      = resp_q;
    assign pending_o       = pending_q;
    assign protocol_err_o  = err_q;

endmodule
